// File: rtl/vend_pkg.sv
// Shared vending-datapath types: coin identifiers, coin values in nickel units,
// and the change-dispenser state encoding.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PULSE  = 2'd2,
    DONE   = 2'd3
  } cd_state_e;

  localparam int unsigned NICKEL_U  = 1;
  localparam int unsigned DIME_U    = 2;
  localparam int unsigned QUARTER_U = 5;

  function automatic int unsigned coin_value(coin_e c);
    case (c)
      QUARTER: return QUARTER_U;
      DIME:    return DIME_U;
      NICKEL:  return NICKEL_U;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Single-denomination coin counter: reloads to INIT on load, counts down on dec,
// saturating at zero.
module coin_inventory #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             empty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= WIDTH'(INIT);
    end else if (load) begin
      cnt <= WIDTH'(INIT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign empty = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change pay-out: quarters, then dimes, then nickels, one coin at a time
// through a pulse/ack hopper handshake with a sticky timeout fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W   = 3,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned Q_INIT  = 4,
  parameter int unsigned D_INIT  = 8,
  parameter int unsigned N_INIT  = 8,
  parameter int unsigned ACK_TMO = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_refill,
  input  logic             i_hop_ack,
  output logic             o_quarter,
  output logic             o_dime,
  output logic             o_nickel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_short,
  output logic             o_fault,
  output logic [AMT_W-1:0] o_remain,
  output logic [CNT_W-1:0] o_q_cnt,
  output logic [CNT_W-1:0] o_d_cnt,
  output logic [CNT_W-1:0] o_n_cnt
);

  localparam int unsigned TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

  cd_state_e        state;
  coin_e            coin;
  coin_e            pick;
  logic [AMT_W-1:0] rem;
  logic [TMO_W-1:0] tmo_cnt;
  logic             shrt;
  logic             fault;
  logic             q_empty, d_empty, n_empty;
  logic             accept, load, ack_hit;

  assign accept  = (state == IDLE) && i_req && !fault;
  assign load    = (state == IDLE) && i_refill && !accept;
  assign ack_hit = (state == PULSE) && i_hop_ack;

  coin_inventory #(.WIDTH(CNT_W), .INIT(Q_INIT)) u_q_inv (
    .clk(i_clk), .rst_n(i_rst_n), .load(load),
    .dec(ack_hit && (coin == QUARTER)), .cnt(o_q_cnt), .empty(q_empty)
  );

  coin_inventory #(.WIDTH(CNT_W), .INIT(D_INIT)) u_d_inv (
    .clk(i_clk), .rst_n(i_rst_n), .load(load),
    .dec(ack_hit && (coin == DIME)), .cnt(o_d_cnt), .empty(d_empty)
  );

  coin_inventory #(.WIDTH(CNT_W), .INIT(N_INIT)) u_n_inv (
    .clk(i_clk), .rst_n(i_rst_n), .load(load),
    .dec(ack_hit && (coin == NICKEL)), .cnt(o_n_cnt), .empty(n_empty)
  );

  // rem==0 fails every compare, so NONE here covers both "finished" and "short"
  always_comb begin
    pick = NONE;
    if ((32'(rem) >= QUARTER_U) && !q_empty) begin
      pick = QUARTER;
    end else if ((32'(rem) >= DIME_U) && !d_empty) begin
      pick = DIME;
    end else if ((32'(rem) >= NICKEL_U) && !n_empty) begin
      pick = NICKEL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      coin    <= NONE;
      rem     <= '0;
      tmo_cnt <= '0;
      shrt    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem   <= i_amount;
            shrt  <= 1'b0;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (rem == '0) begin
            state <= DONE;
          end else if (pick == NONE) begin
            shrt  <= 1'b1;
            state <= DONE;
          end else begin
            coin    <= pick;
            tmo_cnt <= '0;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (i_hop_ack) begin
            coin  <= NONE;
            rem   <= rem - AMT_W'(coin_value(coin));
            state <= SELECT;
          end else if (tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
            coin  <= NONE;
            fault <= 1'b1;
            shrt  <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_quarter = (coin == QUARTER);
  assign o_dime    = (coin == DIME);
  assign o_nickel  = (coin == NICKEL);
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);
  assign o_short   = shrt;
  assign o_fault   = fault;
  assign o_remain  = rem;

endmodule
